oldland_operand_unit: RTL and testbench

Parametrised register file with integrated operand forwarding and a load-use scoreboard. It sits between decode and execute in the oldland pipeline. It captures decode-stage register selects and presents forwarded execute-stage operands. It tracks outstanding loads per destination register and stalls decode until their data returns from the memory stage, since memory latency is variable.

---
 rtl/oldland_operand_unit_if.sv | 29 ++
 rtl/oldland_operand_unit.sv | 119 +++++++++++
 tb/tb_oldland_operand_unit.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/oldland_operand_unit_if.sv
// Decode, execute and writeback signal bundle for oldland_operand_unit.
interface oldland_operand_unit_if #(
  parameter int DATA_WIDTH = 32,
  parameter int SEL_WIDTH  = 3
);
  logic                  dec_valid, flush, uses_ra, uses_rb, dec_is_load, stall;
  logic [SEL_WIDTH-1:0]  ra_sel, rb_sel, rd_sel;
  logic                  ex_update_rd, ex_is_load;
  logic [SEL_WIDTH-1:0]  ex_rd_sel;
  logic [DATA_WIDTH-1:0] ex_result;
  logic                  wb_update_rd, wb_load_done;
  logic [SEL_WIDTH-1:0]  wb_rd_sel;
  logic [DATA_WIDTH-1:0] wb_val;
  logic [DATA_WIDTH-1:0] ra, rb;

  modport master (
    output dec_valid, flush, ra_sel, rb_sel, uses_ra, uses_rb, rd_sel, dec_is_load,
           ex_update_rd, ex_is_load, ex_rd_sel, ex_result,
           wb_update_rd, wb_rd_sel, wb_val, wb_load_done,
    input  stall, ra, rb
  );

  modport slave (
    input  dec_valid, flush, ra_sel, rb_sel, uses_ra, uses_rb, rd_sel, dec_is_load,
           ex_update_rd, ex_is_load, ex_rd_sel, ex_result,
           wb_update_rd, wb_rd_sel, wb_val, wb_load_done,
    output stall, ra, rb
  );
endinterface

// File: rtl/oldland_operand_unit.sv
// Register file with execute-stage operand forwarding and a per-register
// outstanding-load scoreboard that stalls decode on load-use hazards.
module oldland_pend_ctr #(
  parameter int PEND_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inc,
  input  logic                  dec,
  output logic [PEND_WIDTH-1:0] cnt
);
  // Simultaneous inc/dec cancel; a decrement at zero is absorbed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                           cnt <= '0;
    else if (inc && !dec)              cnt <= cnt + 1'b1;
    else if (dec && !inc && cnt != '0) cnt <= cnt - 1'b1;
  end
endmodule

module oldland_operand_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 8,
  parameter int SEL_WIDTH  = 3,
  parameter int PEND_WIDTH = 2,
  parameter int R0_ZERO    = 0
) (
  input logic                   clk,
  input logic                   rst,
  oldland_operand_unit_if.slave bus
);
  localparam logic [PEND_WIDTH-1:0] PEND_ONE = PEND_WIDTH'(1);
  localparam logic [PEND_WIDTH-1:0] PEND_MAX = '1;

  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] file;
  logic [NUM_REGS-1:0][PEND_WIDTH-1:0] pend;
  logic [NUM_REGS-1:0]                 inc, dec;
  logic [1:0][SEL_WIDTH-1:0]           dsel, e_sel, rd_addr;
  logic [1:0][DATA_WIDTH-1:0]          cap, opnd;
  logic [1:0]                          uses, haz;
  logic                                wr_en, ld_done, full, stall, issue, cap_en;

  function automatic logic exempt(input logic [SEL_WIDTH-1:0] s);
    return (R0_ZERO != 0) && (s == '0);
  endfunction

  assign dsel    = {bus.rb_sel, bus.ra_sel};
  assign uses    = {bus.uses_rb, bus.uses_ra};
  assign wr_en   = bus.wb_update_rd && !exempt(bus.wb_rd_sel);
  assign ld_done = wr_en && bus.wb_load_done;

  // A load completing this edge with a single pending entry no longer
  // blocks: the dependent issues now and picks up wb_val write-first.
  always_comb begin
    haz = '0;
    for (int i = 0; i < 2; i++)
      haz[i] = uses[i] && !exempt(dsel[i]) && pend[dsel[i]] != '0 &&
               !(ld_done && bus.wb_rd_sel == dsel[i] && pend[dsel[i]] == PEND_ONE);
    full = bus.dec_is_load && !exempt(bus.rd_sel) && pend[bus.rd_sel] == PEND_MAX;
  end

  assign stall     = bus.dec_valid && ((|haz) || full);
  assign bus.stall = stall;
  assign issue     = bus.dec_valid && !stall && !bus.flush;
  assign cap_en    = bus.flush || !stall;

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_pend
    assign inc[r] = issue && bus.dec_is_load && !exempt(bus.rd_sel) &&
                    bus.rd_sel == SEL_WIDTH'(r);
    assign dec[r] = ld_done && bus.wb_rd_sel == SEL_WIDTH'(r);
    oldland_pend_ctr #(.PEND_WIDTH(PEND_WIDTH)) u_ctr (
      .clk (clk),
      .rst (rst),
      .inc (inc[r]),
      .dec (dec[r]),
      .cnt (pend[r])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        file <= '0;
    else if (wr_en) file[bus.wb_rd_sel] <= bus.wb_val;
  end

  // While held, the captured select is re-read every edge so writes that
  // land during a stall are never lost.
  always_comb begin
    rd_addr = e_sel;
    for (int i = 0; i < 2; i++)
      rd_addr[i] = cap_en ? dsel[i] : e_sel[i];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e_sel <= '0;
      cap   <= '0;
    end else begin
      e_sel <= rd_addr;
      for (int i = 0; i < 2; i++)
        cap[i] <= (wr_en && bus.wb_rd_sel == rd_addr[i]) ? bus.wb_val : file[rd_addr[i]];
    end
  end

  always_comb begin
    opnd = '0;
    for (int i = 0; i < 2; i++) begin
      if (exempt(e_sel[i]))
        opnd[i] = '0;
      else if (bus.ex_update_rd && !bus.ex_is_load && bus.ex_rd_sel == e_sel[i])
        opnd[i] = bus.ex_result;
      else if (bus.wb_update_rd && bus.wb_rd_sel == e_sel[i])
        opnd[i] = bus.wb_val;
      else
        opnd[i] = cap[i];
    end
  end

  assign bus.ra = opnd[0];
  assign bus.rb = opnd[1];
endmodule

// File: tb/tb_oldland_operand_unit.sv
// Drives a default unit (8x32, R0_ZERO=0) and a wide unit (32x64, R0_ZERO=1)
// from one stimulus stream and compares both against a behavioural model.
module tb_oldland_operand_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  oldland_operand_unit_if #(.DATA_WIDTH(32), .SEL_WIDTH(3)) bus0 ();
  oldland_operand_unit_if #(.DATA_WIDTH(64), .SEL_WIDTH(5)) bus1 ();

  oldland_operand_unit #(.DATA_WIDTH(32), .NUM_REGS(8), .SEL_WIDTH(3),
                         .PEND_WIDTH(2), .R0_ZERO(0)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
  oldland_operand_unit #(.DATA_WIDTH(64), .NUM_REGS(32), .SEL_WIDTH(5),
                         .PEND_WIDTH(2), .R0_ZERO(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int n_chk = 0;
  int n_err = 0;

  // Stimulus at the widest geometry; unit 0 sees the low bits.
  logic        s_dec_valid, s_flush, s_dec_is_load, s_ex_upd, s_ex_ld, s_wb_upd, s_wb_ld;
  logic [1:0]  s_uses;
  logic [4:0]  s_sel [2];
  logic [4:0]  s_rd, s_ex_rd, s_wb_rd;
  logic [63:0] s_ex_res, s_wb_val;

  // Reference model state per unit.
  localparam int PMAX = 3;
  logic [63:0] m_file [2][32];
  int          m_pend [2][32];
  int          m_esel [2][2];
  logic [63:0] m_cap  [2][2];

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic int ms(int u, logic [4:0] x);
    return (u == 0) ? int'(x[2:0]) : int'(x);
  endfunction
  function automatic logic [63:0] md(int u, logic [63:0] x);
    return (u == 0) ? {32'h0, x[31:0]} : x;
  endfunction
  function automatic bit zr(int u, int r);
    return (u == 1) && (r == 0);
  endfunction

  function automatic bit m_stall(int u);
    bit h = 0;
    int rd = ms(u, s_rd);
    int wr = ms(u, s_wb_rd);
    for (int i = 0; i < 2; i++) begin
      int r = ms(u, s_sel[i]);
      bit clears = s_wb_upd && s_wb_ld && wr == r && m_pend[u][r] == 1;
      if (s_uses[i] && !zr(u, r) && m_pend[u][r] > 0 && !clears) h = 1;
    end
    if (s_dec_is_load && !zr(u, rd) && m_pend[u][rd] == PMAX) h = 1;
    return s_dec_valid && h;
  endfunction

  function automatic logic [63:0] m_opnd(int u, int i);
    int r = m_esel[u][i];
    if (zr(u, r)) return 64'h0;
    if (s_ex_upd && !s_ex_ld && ms(u, s_ex_rd) == r) return md(u, s_ex_res);
    if (s_wb_upd && ms(u, s_wb_rd) == r) return md(u, s_wb_val);
    return m_cap[u][i];
  endfunction

  task automatic m_step(int u);
    bit st = m_stall(u);
    bit issue = s_dec_valid && !st && !s_flush;
    int wr = ms(u, s_wb_rd);
    int rd = ms(u, s_rd);
    bit we = s_wb_upd && !zr(u, wr);
    bit inc = issue && s_dec_is_load && !zr(u, rd);
    bit dec = we && s_wb_ld;
    if (s_flush || !st)
      for (int i = 0; i < 2; i++) m_esel[u][i] = ms(u, s_sel[i]);
    for (int i = 0; i < 2; i++)
      m_cap[u][i] = (we && wr == m_esel[u][i]) ? md(u, s_wb_val) : m_file[u][m_esel[u][i]];
    if (we) m_file[u][wr] = md(u, s_wb_val);
    if (inc && !(dec && wr == rd)) m_pend[u][rd]++;
    if (dec && !(inc && wr == rd) && m_pend[u][wr] > 0) m_pend[u][wr]--;
  endtask

  task automatic m_reset();
    for (int u = 0; u < 2; u++) begin
      for (int r = 0; r < 32; r++) begin
        m_file[u][r] = '0;
        m_pend[u][r] = 0;
      end
      for (int i = 0; i < 2; i++) begin
        m_esel[u][i] = 0;
        m_cap[u][i]  = '0;
      end
    end
  endtask

  task automatic idle();
    s_dec_valid = 0; s_flush = 0; s_dec_is_load = 0; s_uses = '0;
    s_ex_upd = 0; s_ex_ld = 0; s_wb_upd = 0; s_wb_ld = 0;
    s_sel[0] = '0; s_sel[1] = '0; s_rd = '0; s_ex_rd = '0; s_wb_rd = '0;
    s_ex_res = '0; s_wb_val = '0;
  endtask

  task automatic drive();
    bus0.dec_valid = s_dec_valid;   bus1.dec_valid = s_dec_valid;
    bus0.flush = s_flush;           bus1.flush = s_flush;
    bus0.uses_ra = s_uses[0];       bus1.uses_ra = s_uses[0];
    bus0.uses_rb = s_uses[1];       bus1.uses_rb = s_uses[1];
    bus0.dec_is_load = s_dec_is_load; bus1.dec_is_load = s_dec_is_load;
    bus0.ra_sel = s_sel[0][2:0];    bus1.ra_sel = s_sel[0];
    bus0.rb_sel = s_sel[1][2:0];    bus1.rb_sel = s_sel[1];
    bus0.rd_sel = s_rd[2:0];        bus1.rd_sel = s_rd;
    bus0.ex_update_rd = s_ex_upd;   bus1.ex_update_rd = s_ex_upd;
    bus0.ex_is_load = s_ex_ld;      bus1.ex_is_load = s_ex_ld;
    bus0.ex_rd_sel = s_ex_rd[2:0];  bus1.ex_rd_sel = s_ex_rd;
    bus0.ex_result = s_ex_res[31:0]; bus1.ex_result = s_ex_res;
    bus0.wb_update_rd = s_wb_upd;   bus1.wb_update_rd = s_wb_upd;
    bus0.wb_load_done = s_wb_ld;    bus1.wb_load_done = s_wb_ld;
    bus0.wb_rd_sel = s_wb_rd[2:0];  bus1.wb_rd_sel = s_wb_rd;
    bus0.wb_val = s_wb_val[31:0];   bus1.wb_val = s_wb_val;
  endtask

  // Apply s_* away from the active edge, check outputs, advance the model.
  task automatic cycle();
    @(negedge clk);
    drive();
    #1;
    chk("stall0", 64'(bus0.stall), 64'(m_stall(0)));
    chk("ra0", 64'(bus0.ra), m_opnd(0, 0));
    chk("rb0", 64'(bus0.rb), m_opnd(0, 1));
    chk("stall1", 64'(bus1.stall), 64'(m_stall(1)));
    chk("ra1", bus1.ra, m_opnd(1, 0));
    chk("rb1", bus1.rb, m_opnd(1, 1));
    m_step(0);
    m_step(1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    drive();
    rst = 1'b1;
    #1;
    m_reset();
    chk("rst_ra0", 64'(bus0.ra), 64'h0);
    chk("rst_rb1", bus1.rb, 64'h0);
    chk("rst_stall0", 64'(bus0.stall), 64'h0);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  function automatic logic [4:0] rsel();
    return ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    drive();
    m_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    idle(); cycle();
    chk("reset_ra0", 64'(bus0.ra), 64'h0);

    // Write then read r3.
    idle(); s_wb_upd = 1; s_wb_rd = 3; s_wb_val = 64'hDEADBEEF; cycle();
    idle(); s_dec_valid = 1; s_sel[0] = 3; cycle();
    idle(); cycle();
    chk("r3_read0", 64'(bus0.ra), 64'hDEADBEEF);

    // ALU forwarding, ex over wb.
    idle(); s_dec_valid = 1; s_sel[0] = 2; cycle();
    idle(); s_dec_valid = 1; s_sel[0] = 2; s_ex_upd = 1; s_ex_rd = 2; s_ex_res = 64'h11; cycle();
    chk("fwd_ex0", 64'(bus0.ra), 64'h11);
    idle(); s_ex_upd = 1; s_ex_rd = 2; s_ex_res = 64'h22;
    s_wb_upd = 1; s_wb_rd = 2; s_wb_val = 64'h33; cycle();
    chk("fwd_prio0", 64'(bus0.ra), 64'h22);

    // Load-use on r4, acknowledged after five stalled cycles.
    idle(); s_dec_valid = 1; s_dec_is_load = 1; s_rd = 4; cycle();
    for (int k = 0; k < 5; k++) begin
      idle(); s_dec_valid = 1; s_uses = 2'b01; s_sel[0] = 4; cycle();
      chk("lu_stall0", 64'(bus0.stall), 64'h1);
    end
    idle(); s_dec_valid = 1; s_uses = 2'b01; s_sel[0] = 4;
    s_wb_upd = 1; s_wb_ld = 1; s_wb_rd = 4; s_wb_val = 64'hCAFE0004; cycle();
    chk("lu_release0", 64'(bus0.stall), 64'h0);
    idle(); cycle();
    chk("lu_data0", 64'(bus0.ra), 64'hCAFE0004);
    idle(); s_dec_valid = 1; s_uses = 2'b01; s_sel[0] = 4; cycle();
    chk("lu_clear0", 64'(bus0.stall), 64'h0);

    // Counter saturation on r5.
    for (int k = 0; k < 3; k++) begin
      idle(); s_dec_valid = 1; s_dec_is_load = 1; s_rd = 5; cycle();
    end
    idle(); s_dec_valid = 1; s_dec_is_load = 1; s_rd = 5; cycle();
    chk("full0", 64'(bus0.stall), 64'h1);
    idle(); s_dec_valid = 1; s_dec_is_load = 1; s_rd = 5;
    s_wb_upd = 1; s_wb_ld = 1; s_wb_rd = 5; cycle();
    chk("full_done0", 64'(bus0.stall), 64'h1);
    idle(); s_dec_valid = 1; s_dec_is_load = 1; s_rd = 5;
    s_wb_upd = 1; s_wb_ld = 1; s_wb_rd = 5; cycle();
    chk("incdec_issue0", 64'(bus0.stall), 64'h0);
    idle(); s_dec_valid = 1; s_dec_is_load = 1; s_rd = 5; cycle();
    chk("refill0", 64'(bus0.stall), 64'h0);
    idle(); s_dec_valid = 1; s_dec_is_load = 1; s_rd = 5; cycle();
    chk("refull0", 64'(bus0.stall), 64'h1);

    // Reset drops outstanding loads.
    do_reset();
    idle(); s_dec_valid = 1; s_uses = 2'b01; s_sel[0] = 5; cycle();
    chk("rst_pend0", 64'(bus0.stall), 64'h0);

    // Register 0 handling.
    idle(); s_wb_upd = 1; s_wb_rd = 0; s_wb_val = 64'h55; cycle();
    idle(); s_dec_valid = 1; s_sel[0] = 0; cycle();
    idle(); cycle();
    chk("r0_plain0", 64'(bus0.ra), 64'h55);
    chk("r0_zero1", bus1.ra, 64'h0);
    idle(); s_dec_valid = 1; s_dec_is_load = 1; s_rd = 0; cycle();
    idle(); s_dec_valid = 1; s_uses = 2'b01; s_sel[0] = 0; cycle();
    chk("r0_nostall1", 64'(bus1.stall), 64'h0);
    chk("r0_stall0", 64'(bus0.stall), 64'h1);
    idle(); s_wb_upd = 1; s_wb_ld = 1; s_wb_rd = 0; s_wb_val = 64'h77; cycle();

    // Flushed load leaves the scoreboard alone.
    idle(); s_dec_valid = 1; s_flush = 1; s_dec_is_load = 1; s_rd = 6; cycle();
    idle(); s_dec_valid = 1; s_uses = 2'b01; s_sel[0] = 6; cycle();
    chk("flush0", 64'(bus0.stall), 64'h0);
    chk("flush1", 64'(bus1.stall), 64'h0);

    // Wide round trip through r31.
    idle(); s_wb_upd = 1; s_wb_rd = 31; s_wb_val = 64'hFFFF_FFFF_0000_0001; cycle();
    idle(); s_dec_valid = 1; s_sel[0] = 31; cycle();
    idle(); cycle();
    chk("r31_1", bus1.ra, 64'hFFFF_FFFF_0000_0001);
    chk("r7_0", 64'(bus0.ra), 64'h1);

    // Randomized traffic with one reset in the middle.
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) do_reset();
      s_dec_valid   = ($urandom_range(0, 3) != 0);
      s_flush       = ($urandom_range(0, 9) == 0);
      s_dec_is_load = ($urandom_range(0, 2) == 0);
      s_uses        = 2'($urandom_range(0, 3));
      s_sel[0]      = rsel();
      s_sel[1]      = rsel();
      s_rd          = rsel();
      s_ex_upd      = ($urandom_range(0, 1) != 0);
      s_ex_ld       = ($urandom_range(0, 3) == 0);
      s_ex_rd       = rsel();
      s_ex_res      = {$urandom, $urandom};
      s_wb_upd      = ($urandom_range(0, 1) != 0);
      s_wb_ld       = ($urandom_range(0, 4) < 2);
      s_wb_rd       = rsel();
      s_wb_val      = {$urandom, $urandom};
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
